// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad authenticator: key codes, FSM states,
// default credential table and a small key-classification helper.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_USER  = 3'd1,
        ST_PASS  = 3'd2,
        ST_CHECK = 3'd3,
        ST_LOCK  = 3'd4
    } state_t;

    // Default table for 4 users, 3-digit usernames and 4-digit passwords; entry 0 is in the low digits.
    localparam logic [47:0] DEF_USER_TABLE = 48'h999_042_777_123;
    localparam logic [63:0] DEF_PASS_TABLE = 64'h9876_1234_0000_4567;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_cred_rom.sv
// Combinational credential lookup: reports whether the BCD username/password
// pair appears in the table and, if so, the lowest matching index.
module keypad_cred_rom
    import keypad_pkg::*;
#(
    parameter int USER_DIGITS = 3,
    parameter int PASS_DIGITS = 4,
    parameter int NUM_USERS   = 4,
    parameter logic [NUM_USERS*USER_DIGITS*4-1:0] USER_TABLE = DEF_USER_TABLE,
    parameter logic [NUM_USERS*PASS_DIGITS*4-1:0] PASS_TABLE = DEF_PASS_TABLE
) (
    input  logic [USER_DIGITS*4-1:0]     user,
    input  logic [PASS_DIGITS*4-1:0]     pass,
    output logic                         hit,
    output logic [$clog2(NUM_USERS)-1:0] index
);

    localparam int UW = USER_DIGITS * 4;
    localparam int PW = PASS_DIGITS * 4;
    localparam int IW = $clog2(NUM_USERS);

    // Scan from the top so the lowest matching entry wins.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (user == USER_TABLE[i*UW +: UW] && pass == PASS_TABLE[i*PW +: PW]) begin
                hit   = 1'b1;
                index = i[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/keypad_auth.sv
// Keypad authenticator: collects "* user # pass #" entries, checks them
// against the credential table, and locks out after repeated denials.
module keypad_auth
    import keypad_pkg::*;
#(
    parameter int USER_DIGITS = 3,
    parameter int PASS_DIGITS = 4,
    parameter int NUM_USERS   = 4,
    parameter int MAX_FAIL    = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCK_CYC    = 5000,
    parameter logic [NUM_USERS*USER_DIGITS*4-1:0] USER_TABLE = DEF_USER_TABLE,
    parameter logic [NUM_USERS*PASS_DIGITS*4-1:0] PASS_TABLE = DEF_PASS_TABLE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         grant,
    output logic                         deny,
    output logic [$clog2(NUM_USERS)-1:0] user_id,
    output logic                         locked,
    output logic                         busy
);

    localparam int UW  = USER_DIGITS * 4;
    localparam int PW  = PASS_DIGITS * 4;
    localparam int IW  = $clog2(NUM_USERS);
    localparam int UCW = $clog2(USER_DIGITS + 1);
    localparam int PCW = $clog2(PASS_DIGITS + 1);
    localparam int FW  = $clog2(MAX_FAIL + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int LW  = $clog2(LOCK_CYC + 1);

    state_t          state, state_nxt;
    logic [UW-1:0]   user_reg;
    logic [PW-1:0]   pass_reg;
    logic [UCW-1:0]  user_cnt;
    logic [PCW-1:0]  pass_cnt;
    logic            user_ovf, pass_ovf;
    logic [FW-1:0]   fail_cnt;
    logic [TW-1:0]   idle_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            grant_q, deny_q;
    logic [IW-1:0]   user_id_q;
    logic            rom_hit;
    logic [IW-1:0]   rom_index;

    logic key_digit, key_star, key_hash, key_any;
    logic entering, timed_out, entry_ok, fail_limit, lock_done;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_star   = key_valid && key_code == KEY_STAR;
    assign key_hash   = key_valid && key_code == KEY_HASH;
    assign key_any    = key_digit || key_star || key_hash;
    assign entering   = state == ST_USER || state == ST_PASS;
    assign timed_out  = entering && !key_any && idle_cnt == TW'(TIMEOUT_CYC - 1);
    assign entry_ok   = rom_hit && !user_ovf && !pass_ovf &&
                        user_cnt == UCW'(USER_DIGITS) && pass_cnt == PCW'(PASS_DIGITS);
    assign fail_limit = fail_cnt >= FW'(MAX_FAIL - 1);
    assign lock_done  = lock_cnt == LW'(LOCK_CYC - 1);

    keypad_cred_rom #(
        .USER_DIGITS (USER_DIGITS),
        .PASS_DIGITS (PASS_DIGITS),
        .NUM_USERS   (NUM_USERS),
        .USER_TABLE  (USER_TABLE),
        .PASS_TABLE  (PASS_TABLE)
    ) u_rom (
        .user  (user_reg),
        .pass  (pass_reg),
        .hit   (rom_hit),
        .index (rom_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (key_star) state_nxt = ST_USER;
            ST_USER: begin
                if (key_hash)       state_nxt = ST_PASS;
                else if (timed_out) state_nxt = ST_IDLE;
            end
            ST_PASS: begin
                if (key_hash)       state_nxt = ST_CHECK;
                else if (key_star)  state_nxt = ST_USER;
                else if (timed_out) state_nxt = ST_IDLE;
            end
            ST_CHECK: state_nxt = (!entry_ok && fail_limit) ? ST_LOCK : ST_IDLE;
            ST_LOCK:  if (lock_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = state != ST_IDLE;
        locked  = state == ST_LOCK;
        grant   = grant_q;
        deny    = deny_q;
        user_id = user_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            user_reg  <= '0;
            pass_reg  <= '0;
            user_cnt  <= '0;
            pass_cnt  <= '0;
            user_ovf  <= 1'b0;
            pass_ovf  <= 1'b0;
            fail_cnt  <= '0;
            idle_cnt  <= '0;
            lock_cnt  <= '0;
            grant_q   <= 1'b0;
            deny_q    <= 1'b0;
            user_id_q <= '0;
        end else begin
            grant_q <= state == ST_CHECK && entry_ok;
            deny_q  <= state == ST_CHECK && !entry_ok;

            // Star always restarts a fresh entry; extra digits only raise the overlength flag.
            if ((state == ST_IDLE || entering) && key_star) begin
                user_reg <= '0;
                pass_reg <= '0;
                user_cnt <= '0;
                pass_cnt <= '0;
                user_ovf <= 1'b0;
                pass_ovf <= 1'b0;
            end else if (state == ST_USER && key_digit) begin
                if (user_cnt == UCW'(USER_DIGITS)) begin
                    user_ovf <= 1'b1;
                end else begin
                    user_reg <= (user_reg << 4) | UW'(key_code);
                    user_cnt <= user_cnt + UCW'(1);
                end
            end else if (state == ST_PASS && key_digit) begin
                if (pass_cnt == PCW'(PASS_DIGITS)) begin
                    pass_ovf <= 1'b1;
                end else begin
                    pass_reg <= (pass_reg << 4) | PW'(key_code);
                    pass_cnt <= pass_cnt + PCW'(1);
                end
            end

            if (!entering || key_any)               idle_cnt <= '0;
            else if (idle_cnt != TW'(TIMEOUT_CYC))  idle_cnt <= idle_cnt + TW'(1);

            if (state == ST_LOCK && !lock_done) lock_cnt <= lock_cnt + LW'(1);
            else                                lock_cnt <= '0;

            if (state == ST_CHECK) begin
                if (entry_ok) begin
                    fail_cnt  <= '0;
                    user_id_q <= rom_index;
                end else if (fail_cnt != FW'(MAX_FAIL)) begin
                    fail_cnt <= fail_cnt + FW'(1);
                end
            end else if (state == ST_LOCK && lock_done) begin
                fail_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_auth.sv
// Self-checking bench for keypad_auth: directed scenarios plus randomized
// entries predicted by a digit-queue/table reference model.
module tb_keypad_auth;
    import keypad_pkg::*;

    localparam int LOCK_CYC    = 5000;
    localparam int TIMEOUT_CYC = 1000;
    localparam int MAX_FAIL    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       grant, deny, locked, busy;
    logic [1:0] user_id;

    int n_checks = 0;
    int n_fail = 0;
    int grant_seen = 0;
    int deny_seen = 0;

    // Reference credentials as decimal numbers; entry 0 is the required 123/4567.
    int m_user[4] = '{123, 555, 908, 246};
    int m_pass[4] = '{4567, 1, 3141, 8080};
    int model_fails = 0;
    int model_uid = 0;
    int u_q[$];
    int p_q[$];
    bit noisy = 1'b0;

    keypad_auth #(
        .USER_TABLE (48'h246_908_555_123),
        .PASS_TABLE (64'h8080_3141_0001_4567)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .grant     (grant),
        .deny      (deny),
        .user_id   (user_id),
        .locked    (locked),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        grant_seen += int'(grant);
        deny_seen  += int'(deny);
        n_checks++;
        if (grant === 1'b1 && deny === 1'b1) begin
            n_fail++;
            $display("FAIL exclusive: grant=%0b deny=%0b, both must not be high", grant, deny);
        end
    end

    initial begin
        #900_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic int model_lookup();
        int uv = 0;
        int pv = 0;
        if (u_q.size() != 3 || p_q.size() != 4) return -1;
        foreach (u_q[i]) uv = uv * 10 + u_q[i];
        foreach (p_q[i]) pv = pv * 10 + p_q[i];
        for (int k = 0; k < 4; k++)
            if (m_user[k] == uv && m_pass[k] == pv) return k;
        return -1;
    endfunction

    task automatic send_key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic gap();
        int g;
        g = noisy ? $urandom_range(0, 2) : 0;
        repeat (g) begin
            if ($urandom_range(0, 1) == 1) begin
                key_valid = 1'b1;
                key_code  = 4'($urandom_range(12, 15));
            end
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic submit(input string name);
        int idx;
        bit exp_lock;
        int len;
        int g0, d0;
        idx = model_lookup();
        gap(); send_key(KEY_STAR);
        foreach (u_q[i]) begin gap(); send_key(4'(u_q[i])); end
        gap(); send_key(KEY_HASH);
        foreach (p_q[i]) begin gap(); send_key(4'(p_q[i])); end
        gap(); send_key(KEY_HASH);

        n_checks++;
        if (grant !== 1'b0 || deny !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s check_cycle: grant=%0b deny=%0b busy=%0b expected 0 0 1", name, grant, deny, busy);
        end
        @(negedge clk);
        if (idx >= 0) begin
            model_fails = 0;
            model_uid   = idx;
            exp_lock    = 1'b0;
        end else begin
            model_fails++;
            exp_lock = model_fails >= MAX_FAIL;
        end
        n_checks++;
        if (grant !== (idx >= 0) || deny !== (idx < 0)) begin
            n_fail++;
            $display("FAIL %s result: grant=%0b deny=%0b expected grant=%0b deny=%0b", name, grant, deny, idx >= 0, idx < 0);
        end
        n_checks++;
        if (user_id !== 2'(model_uid)) begin
            n_fail++;
            $display("FAIL %s user_id: got %0d expected %0d", name, user_id, model_uid);
        end
        n_checks++;
        if (locked !== exp_lock || busy !== exp_lock) begin
            n_fail++;
            $display("FAIL %s post_state: locked=%0b busy=%0b expected %0b %0b", name, locked, busy, exp_lock, exp_lock);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 1'b0 || deny !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_width: grant=%0b deny=%0b expected 0 0", name, grant, deny);
        end

        if (exp_lock) begin
            len = (locked === 1'b1) ? 2 : 1;
            g0 = grant_seen;
            d0 = deny_seen;
            while (locked === 1'b1 && len < LOCK_CYC + 100) begin
                key_valid = $urandom_range(0, 1) == 1;
                key_code  = 4'($urandom_range(0, 11));
                @(negedge clk);
                key_valid = 1'b0;
                if (locked === 1'b1) len++;
            end
            model_fails = 0;
            n_checks++;
            if (len != LOCK_CYC) begin
                n_fail++;
                $display("FAIL %s lock_len: locked for %0d cycles expected %0d", name, len, LOCK_CYC);
            end
            n_checks++;
            if (grant_seen != g0 || deny_seen != d0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s lock_quiet: pulses g=%0d d=%0d busy=%0b expected 0 0 0", name, grant_seen - g0, deny_seen - d0, busy);
            end
        end
    endtask

    task automatic set_entry(input int u, input int ud, input int p, input int pd);
        u_q.delete();
        p_q.delete();
        for (int d = ud - 1; d >= 0; d--) u_q.push_back((u / (10 ** d)) % 10);
        for (int d = pd - 1; d >= 0; d--) p_q.push_back((p / (10 ** d)) % 10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (grant !== 1'b0 || deny !== 1'b0 || locked !== 1'b0 || busy !== 1'b0 || user_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: g=%0b d=%0b l=%0b b=%0b id=%0d expected all 0", grant, deny, locked, busy, user_id);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_grant();
        set_entry(123, 3, 4567, 4);
        submit("grant_basic");
        set_entry(908, 3, 3141, 4);
        submit("grant_user2");
        set_entry(555, 3, 1, 4);
        submit("grant_user1_zeros");
    endtask

    task automatic test_length();
        set_entry(1234, 4, 4567, 4);
        submit("overlength_user");
        set_entry(12, 2, 4567, 4);
        submit("short_user");
        set_entry(123, 3, 4567, 4);
        submit("grant_clears_fails");
    endtask

    task automatic test_lockout();
        for (int i = 0; i < MAX_FAIL; i++) begin
            set_entry(123, 3, 4568, 4);
            submit($sformatf("lockout_deny%0d", i));
        end
        set_entry(123, 3, 4568, 4);
        submit("after_lock_deny");
        set_entry(246, 3, 8080, 4);
        submit("after_lock_grant");
    endtask

    task automatic test_timeout();
        int g0, d0;
        g0 = grant_seen;
        d0 = deny_seen;
        send_key(KEY_STAR);
        send_key(4'd1);
        send_key(4'd2);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: busy=%0b expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant_seen != g0 || deny_seen != d0) begin
            n_fail++;
            $display("FAIL timeout_idle: busy=%0b pulses g=%0d d=%0d expected 0 0 0", busy, grant_seen - g0, deny_seen - d0);
        end
        set_entry(123, 3, 4567, 4);
        submit("timeout_regrant");
    endtask

    task automatic test_restart();
        send_key(KEY_STAR);
        send_key(4'd9);
        send_key(4'd9);
        set_entry(123, 3, 4567, 4);
        submit("star_restart_user");
        send_key(KEY_STAR);
        send_key(4'd1); send_key(4'd2); send_key(4'd3);
        send_key(KEY_HASH);
        send_key(4'd4); send_key(4'd5);
        set_entry(908, 3, 3141, 4);
        submit("star_restart_pass");
        set_entry(123, 3, 45678, 5);
        submit("overlength_pass");
    endtask

    task automatic test_reset_mid();
        int g0, d0;
        send_key(KEY_STAR);
        send_key(4'd1); send_key(4'd2); send_key(4'd3);
        send_key(KEY_HASH);
        send_key(4'd4); send_key(4'd5);
        g0 = grant_seen;
        d0 = deny_seen;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 1'b0 || deny !== 1'b0 || locked !== 1'b0 || busy !== 1'b0 || user_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: g=%0b d=%0b l=%0b b=%0b id=%0d expected all 0", grant, deny, locked, busy, user_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_fails = 0;
        model_uid   = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (grant_seen != g0 || deny_seen != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: pulses g=%0d d=%0d busy=%0b expected 0 0 0", grant_seen - g0, deny_seen - d0, busy);
        end
    endtask

    task automatic test_random();
        int kind, k, ul, pl;
        noisy = 1'b1;
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            k    = $urandom_range(0, 3);
            case (kind)
                0: set_entry(m_user[k], 3, m_pass[k], 4);
                1: begin
                    set_entry(m_user[k], 3, m_pass[k], 4);
                    p_q[$urandom_range(0, 3)] = $urandom_range(0, 9);
                end
                default: begin
                    ul = (kind == 2) ? 3 : $urandom_range(1, 5);
                    pl = (kind == 2) ? 4 : $urandom_range(2, 5);
                    u_q.delete();
                    p_q.delete();
                    for (int d = 0; d < ul; d++) u_q.push_back($urandom_range(0, 9));
                    for (int d = 0; d < pl; d++) p_q.push_back($urandom_range(0, 9));
                end
            endcase
            submit($sformatf("rand%0d", it));
        end
        noisy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_grant();
        test_length();
        test_lockout();
        test_timeout();
        test_restart();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_auth.md
KEYPAD_AUTH -- requirements
Module: keypad_auth

Interface
REQ-001 Parameter USER_DIGITS, default 3: BCD digits in a username.
REQ-002 Parameter PASS_DIGITS, default 4: BCD digits in a password.
REQ-003 Parameter NUM_USERS, default 4: entries in the credential table.
REQ-004 Parameter MAX_FAIL, default 3: consecutive denials that trigger lockout.
REQ-005 Parameter TIMEOUT_CYC, default 1000: idle cycles between keys before an entry is abandoned.
REQ-006 Parameter LOCK_CYC, default 5000: lockout duration in cycles.
REQ-007 Port clk  input  1: single clock; all state on rising edge.
REQ-008 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-009 Port key_valid  input  1: one-cycle strobe, key_code valid.
REQ-010 Port key_code  input  4: 0-9 digit, 4'hA star, 4'hB hash; 4'hC-4'hF ignored.
REQ-011 Port grant  output  1: one-cycle pulse, credentials accepted.
REQ-012 Port deny  output  1: one-cycle pulse, credentials rejected.
REQ-013 Port user_id  output  $clog2(NUM_USERS): matched table index, valid while grant=1, held until next grant.
REQ-014 Port locked  output  1: level, high during lockout.
REQ-015 Port busy  output  1: level, high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, USER, PASS, CHECK, LOCK.
REQ-017 IDLE: star -> USER with digit counter and entry registers cleared; all other keys ignored.
REQ-018 USER: each digit shifts into the username register, most significant first; hash -> PASS; star -> restart USER, cleared.
REQ-019 PASS: each digit shifts into the password register; hash -> CHECK; star -> USER, cleared.
REQ-020 Digit count is per field. A digit beyond the field width sets a sticky overlength flag and is discarded.
REQ-021 In CHECK (one cycle), the entry matches only if both fields have exactly the parameterised digit counts, neither overlength flag is set, and a table entry matches both fields.
REQ-022 On a match, grant pulses on the cycle after CHECK, user_id is loaded, the fail counter is cleared, and the FSM returns to IDLE.
REQ-023 On a mismatch, deny pulses on the cycle after CHECK and the fail counter increments. At MAX_FAIL the FSM goes to LOCK; otherwise it returns to IDLE.
REQ-024 LOCK: locked=1, all keys ignored, for exactly LOCK_CYC cycles; then IDLE, fail counter cleared, locked=0.
REQ-025 Timeout counter resets on every accepted key. In USER or PASS, TIMEOUT_CYC cycles without a key -> IDLE, no deny, fail counter unchanged.
REQ-026 grant and deny are never high together. Keys arriving in CHECK are dropped.
REQ-027 Fail counter saturates at MAX_FAIL. Timeout and lock counters never wrap.

Reset
REQ-028 rst_n low, asynchronously: FSM to IDLE; all counters and registers to 0; grant=0, deny=0, locked=0, busy=0, user_id=0.
REQ-029 Reset mid-entry or mid-lockout abandons the operation with no grant or deny pulse.

Structure
REQ-030 A shared package keypad_pkg holds the key-code constants (KEY_STAR=4'hA, KEY_HASH=4'hB) and the state enum.
REQ-031 Sub-module keypad_cred_rom: combinational lookup taking the username and password, returning hit and index, built from a parameter-initialised table of NUM_USERS entries.
REQ-032 Default table entry 0 is username 123, password 4567.

Verification
REQ-033 Keys * 1 2 3 # 4 5 6 7 # -> grant pulse 1 cycle after CHECK, user_id=0, busy returns to 0.
REQ-034 Keys * 1 2 3 # 4 5 6 8 # entered three times -> three deny pulses, then locked=1 for exactly 5000 cycles, keys ignored throughout.
REQ-035 Keys * 1 2 3 4 # 4 5 6 7 # (overlength username) -> deny. Keys * 1 2 # 4 5 6 7 # (short username) -> deny.
REQ-036 Keys * 1 2 then 1000 idle cycles -> IDLE, no pulse. A following correct entry -> grant.
REQ-037 Keys * 9 9 * 1 2 3 # 4 5 6 7 # (star restart) -> grant. rst_n pulsed low during PASS -> no pulse, all outputs 0.
